// File: rtl/cpu_controller_if.sv
// Opcode package and the controller <-> datapath strobe interface.
// The instr_count signal exists only when VERIRISC_INSTR_CNT_EN is defined.
package opcodes;
  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
    XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
  } opcode_t;
endpackage

interface cpu_controller_if #(parameter int CNT_W = 16);
  import opcodes::*;

  opcode_t     opcode;
  logic        zero;
  logic        sel;
  logic        rd;
  logic        ld_ir;
  logic        inc_pc;
  logic        halt;
  logic        ld_pc;
  logic        data_e;
  logic        ld_ac;
  logic        wr;
  logic [2:0]  phase;
`ifdef VERIRISC_INSTR_CNT_EN
  logic [CNT_W-1:0] instr_count;
`endif

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase
`ifdef VERIRISC_INSTR_CNT_EN
    , output instr_count
`endif
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase
`ifdef VERIRISC_INSTR_CNT_EN
    , input instr_count
`endif
  );
endinterface

// File: rtl/cpu_controller.sv
// VeriRISC 8-phase control sequencer; one instruction per 8 clocks.
// Optional instruction counter enabled by defining VERIRISC_INSTR_CNT_EN.
module cpu_controller #(
  parameter int NPHASE = 8,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  cpu_controller_if.master bus
);
  import opcodes::*;

  if (NPHASE != 8) begin : g_nphase_check
    $error("cpu_controller: NPHASE must be 8");
  end

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0, INST_FETCH = 3'd1, INST_LOAD = 3'd2, IDLE  = 3'd3,
    OP_ADDR    = 3'd4, OP_FETCH   = 3'd5, ALU_OP    = 3'd6, STORE = 3'd7
  } phase_t;

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_hlt_s, is_skz_s, is_jmp_s, is_sto_s, aluop_s;
  logic sel_s, rd_s, ld_ir_s, inc_pc_s, halt_s, ld_pc_s, data_e_s, ld_ac_s, wr_s;

  // Opcode class decode; unknown or X opcodes fall to the no-op default.
  always_comb begin
    is_hlt_s = 1'b0;
    is_skz_s = 1'b0;
    is_jmp_s = 1'b0;
    is_sto_s = 1'b0;
    aluop_s  = 1'b0;
    case (bus.opcode)
      HLT:               is_hlt_s = 1'b1;
      SKZ:               is_skz_s = 1'b1;
      ADD, AND, XOR, LDA: aluop_s = 1'b1;
      STO:               is_sto_s = 1'b1;
      JMP:               is_jmp_s = 1'b1;
      default:           is_hlt_s = 1'b0;
    endcase
  end

  // Phase and halt state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: HLT in OP_ADDR freezes the sequencer at phase 4.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
    end else if ((phase_q == OP_ADDR) && is_hlt_s) begin
      halted_d = 1'b1;
    end else begin
      phase_d = phase_t'(phase_q + 3'd1);
    end
  end

  // Strobe decode from phase, opcode class and zero.
  always_comb begin
    sel_s    = 1'b0;
    rd_s     = 1'b0;
    ld_ir_s  = 1'b0;
    inc_pc_s = 1'b0;
    halt_s   = 1'b0;
    ld_pc_s  = 1'b0;
    data_e_s = 1'b0;
    ld_ac_s  = 1'b0;
    wr_s     = 1'b0;
    if (halted_q) begin
      halt_s = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR:  sel_s = 1'b1;
        INST_FETCH: begin sel_s = 1'b1; rd_s = 1'b1; end
        INST_LOAD, IDLE: begin
          sel_s   = 1'b1;
          rd_s    = 1'b1;
          ld_ir_s = 1'b1;
        end
        OP_ADDR: begin
          inc_pc_s = 1'b1;
          halt_s   = is_hlt_s;
        end
        OP_FETCH: rd_s = aluop_s;
        ALU_OP: begin
          rd_s     = aluop_s;
          inc_pc_s = is_skz_s & bus.zero;
          ld_pc_s  = is_jmp_s;
          data_e_s = is_sto_s;
        end
        STORE: begin
          rd_s     = aluop_s;
          ld_ac_s  = aluop_s;
          ld_pc_s  = is_jmp_s;
          data_e_s = is_sto_s;
          wr_s     = is_sto_s;
        end
        default: sel_s = 1'b1;
      endcase
    end
  end

  assign bus.sel    = sel_s;
  assign bus.rd     = rd_s;
  assign bus.ld_ir  = ld_ir_s;
  assign bus.inc_pc = inc_pc_s;
  assign bus.halt   = halt_s;
  assign bus.ld_pc  = ld_pc_s;
  assign bus.data_e = data_e_s;
  assign bus.ld_ac  = ld_ac_s;
  assign bus.wr     = wr_s;
  assign bus.phase  = phase_q;

`ifdef VERIRISC_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count completed instructions on the 7->0 wrap.
  always_comb begin
    if (!halted_q && (phase_q == STORE)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Instruction counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.instr_count = cnt_q;
`endif
endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed and random instructions
// checked against a phase-rule reference model.
`timescale 1ns/1ps
module tb_cpu_controller;
  import opcodes::*;

`ifdef VERIRISC_INSTR_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int   m_phase;
  bit   m_halted;
  int   m_cnt;

  cpu_controller_if #(.CNT_W(CW)) bus ();
  cpu_controller #(.NPHASE(8), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic int op_code();
    if ($isunknown(bus.opcode)) return -1;
    return int'(bus.opcode);
  endfunction

  // Expected {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} from the phase rules.
  function automatic logic [8:0] expected_strobes(int p, bit h, int oc, logic z);
    bit alu, run;
    logic [8:0] e;
    alu = (oc >= 2) && (oc <= 5);
    run = !h;
    e[8] = run && (p <= 3);
    e[7] = run && (((p >= 1) && (p <= 3)) || ((p >= 5) && alu));
    e[6] = run && ((p == 2) || (p == 3));
    e[5] = run && ((p == 4) || ((p == 6) && (oc == 1) && (z === 1'b1)));
    e[4] = h || ((p == 4) && (oc == 0));
    e[3] = run && (p >= 6) && (oc == 7);
    e[2] = run && (p >= 6) && (oc == 6);
    e[1] = run && (p == 7) && alu;
    e[0] = run && (p == 7) && (oc == 6);
    return e;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_halted = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic check(input string tag);
    logic [8:0] obs, exp_s;
    exp_s = expected_strobes(m_phase, m_halted, op_code(), bus.zero);
    obs = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
           bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};
    checks++;
    assert (obs === exp_s) else begin
      errors++;
      $error("FAIL %s strobes: observed=%b expected=%b (phase %0d)", tag, obs, exp_s, m_phase);
    end
    checks++;
    assert (bus.phase === 3'(m_phase)) else begin
      errors++;
      $error("FAIL %s phase: observed=%0d expected=%0d", tag, bus.phase, m_phase);
    end
`ifdef VERIRISC_INSTR_CNT_EN
    checks++;
    assert (bus.instr_count === CW'(m_cnt)) else begin
      errors++;
      $error("FAIL %s instr_count: observed=%0d expected=%0d", tag, bus.instr_count, m_cnt);
    end
`endif
  endtask

  task automatic step(input string tag);
    int oc;
    @(posedge clk);
    oc = op_code();
    if (!m_halted) begin
      if ((m_phase == 4) && (oc == 0)) begin
        m_halted = 1'b1;
      end else begin
        if (m_phase == 7) m_cnt = (m_cnt + 1) % (1 << CW);
        m_phase = (m_phase + 1) % 8;
      end
    end
    #1;
    check(tag);
  endtask

  task automatic run_instr(input opcode_t op, input logic z, input string tag);
    bus.opcode = op;
    bus.zero   = z;
    repeat (8) step(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release");
  endtask

  initial begin
    rst        = 1'b1;
    bus.opcode = LDA;
    bus.zero   = 1'b0;
    model_reset();
    #1;
    check("reset_initial");
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    run_instr(LDA, 1'b0, "lda");
    run_instr(STO, 1'b0, "sto");
    run_instr(SKZ, 1'b1, "skz_z1");
    run_instr(SKZ, 1'b0, "skz_z0");
    run_instr(JMP, 1'b1, "jmp");
    run_instr(ADD, 1'b0, "add");
    run_instr(AND, 1'b1, "and");
    run_instr(XOR, 1'b0, "xor");

    // zero raised only during phase 5 must not cause a skip
    bus.opcode = SKZ;
    bus.zero   = 1'b0;
    repeat (5) step("skz_toggle");
    bus.zero = 1'b1;
    #1;
    check("skz_toggle_p5");
    bus.zero = 1'b0;
    repeat (3) step("skz_toggle");

    // unknown opcode decodes as a no-op
    bus.opcode = opcode_t'(3'bxxx);
    repeat (8) step("x_opcode");

    // random legal non-halting instructions with zero changing every cycle
    for (int n = 0; n < 24; n++) begin
      bus.opcode = opcode_t'(3'($urandom_range(1, 7)));
      for (int c = 0; c < 8; c++) begin
        bus.zero = 1'($urandom_range(0, 1));
        step("random");
      end
    end

    // counter wrap, then halt
    do_reset();
    repeat (17) run_instr(LDA, 1'b0, "lda17");
`ifdef VERIRISC_INSTR_CNT_EN
    checks++;
    assert (bus.instr_count === 4'd1) else begin
      errors++;
      $error("FAIL cnt_wrap: observed=%0d expected=1", bus.instr_count);
    end
`endif
    bus.opcode = HLT;
    for (int c = 0; c < 26; c++) begin
      bus.zero = 1'($urandom_range(0, 1));
      step("halt");
    end
    checks++;
    assert ((bus.phase === 3'd4) && (bus.halt === 1'b1) && (bus.inc_pc === 1'b0)) else begin
      errors++;
      $error("FAIL halt_hold: observed phase=%0d halt=%b inc_pc=%b expected 4/1/0",
             bus.phase, bus.halt, bus.inc_pc);
    end
`ifdef VERIRISC_INSTR_CNT_EN
    checks++;
    assert (bus.instr_count === 4'd1) else begin
      errors++;
      $error("FAIL cnt_frozen: observed=%0d expected=1", bus.instr_count);
    end
`endif

    // asynchronous reset in the middle of phase 6
    do_reset();
    bus.opcode = STO;
    repeat (6) step("pre_async");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    assert ((bus.phase === 3'd0) && (bus.sel === 1'b1) && (bus.data_e === 1'b0)) else begin
      errors++;
      $error("FAIL async_rst: observed phase=%0d sel=%b data_e=%b expected 0/1/0",
             bus.phase, bus.sel, bus.data_e);
    end
    check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run_instr(JMP, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
